hazard_ctrl_unit: RTL and testbench

//   Stall/flush controller for the 5-stage pipeline; resolves hazards that operand bypassing cannot.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_perf_cnt.sv | 32 +++
 rtl/hazard_ctrl_unit.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// State encodings, register-address width and perf-counter width.
package hazard_pkg;

    localparam int REG_AW_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall and flush event counters for the hazard controller.
// Built only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall_inc,
    input  logic             i_flush_inc,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall_inc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (i_flush_inc && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/freeze/drain controller for the 5-stage pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 16
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W        = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] IF_ID_Rs,
    input  logic [REG_AW-1:0] IF_ID_Rt,
    input  logic              IF_ID_UsesRs,
    input  logic              IF_ID_UsesRt,
    input  logic              IF_ID_MemWrite,
    input  logic              IF_ID_Halt,
    input  logic              ID_EX_MemRead,
    input  logic [REG_AW-1:0] ID_EX_Rd,
    input  logic              branch_taken,
    input  logic              dmem_busy,
    output logic              PC_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              EX_MEM_write,
    output logic              MEM_WB_write,
    output logic              halted,
    output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int BW = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         r_state;
    hz_state_e         w_state_nxt;
    logic [DW-1:0]     r_drain_cnt;
    logic [DW-1:0]     w_drain_nxt;
    logic [BW-1:0]     r_busy_cnt;
    logic [BW-1:0]     w_busy_nxt;
    logic              r_halted;
    logic              w_halted_nxt;
    logic              r_mem_timeout;
    logic              w_tmo_nxt;

    logic              w_load_use;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_freeze;

    // Store data (Rt of a store) is bypassed MEM-to-MEM, so it never stalls.
    assign w_rs_hit   = IF_ID_UsesRs && (ID_EX_Rd == IF_ID_Rs);
    assign w_rt_hit   = IF_ID_UsesRt && (ID_EX_Rd == IF_ID_Rt)
                        && !IF_ID_MemWrite;
    assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != '0)
                        && (w_rs_hit || w_rt_hit);
    assign w_freeze   = dmem_busy && (r_state != ST_HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_busy_cnt    <= '0;
            r_halted      <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_drain_cnt   <= w_drain_nxt;
            r_busy_cnt    <= w_busy_nxt;
            r_halted      <= w_halted_nxt;
            r_mem_timeout <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain_cnt;
        w_busy_nxt   = '0;
        w_halted_nxt = r_halted;
        w_tmo_nxt    = r_mem_timeout;
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b0;
        MEM_WB_write = 1'b0;
        if (!rst_n) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (w_freeze) begin
            w_busy_nxt = r_busy_cnt + 1'b1;
            if (r_busy_cnt == BW'(MEM_TIMEOUT - 1)) begin
                w_tmo_nxt   = 1'b1;
                w_state_nxt = ST_HALTED;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    EX_MEM_write = 1'b1;
                    MEM_WB_write = 1'b1;
                    if (w_load_use) begin
                        ID_EX_flush = 1'b1;
                    end else if (IF_ID_Halt) begin
                        IF_ID_write = 1'b1;
                        IF_ID_flush = 1'b1;
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                        IF_ID_flush = branch_taken;
                    end
                end
                ST_DRAIN: begin
                    ID_EX_flush  = 1'b1;
                    EX_MEM_write = 1'b1;
                    MEM_WB_write = 1'b1;
                    w_drain_nxt  = r_drain_cnt + 1'b1;
                    if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_HALTED;
                end
            endcase
        end
    end

    assign halted      = r_halted;
    assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_ev;
    logic w_flush_ev;

    assign w_stall_ev = rst_n && (w_freeze
                        || ((r_state == ST_RUN) && w_load_use));
    assign w_flush_ev = rst_n && (r_state == ST_RUN) && IF_ID_flush;

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall_inc (w_stall_ev),
        .i_flush_inc (w_flush_ev),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: vector table plus
// hand-written drain, freeze, timeout and reset sequences.
module tb_hazard_ctrl_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] IF_ID_Rs;
    logic [3:0] IF_ID_Rt;
    logic       IF_ID_UsesRs;
    logic       IF_ID_UsesRt;
    logic       IF_ID_MemWrite;
    logic       IF_ID_Halt;
    logic       ID_EX_MemRead;
    logic [3:0] ID_EX_Rd;
    logic       branch_taken;
    logic       dmem_busy;
    logic       PC_write;
    logic       IF_ID_write;
    logic       IF_ID_flush;
    logic       ID_EX_flush;
    logic       EX_MEM_write;
    logic       MEM_WB_write;
    logic       halted;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    hazard_ctrl_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF_ID_Rs       (IF_ID_Rs),
        .IF_ID_Rt       (IF_ID_Rt),
        .IF_ID_UsesRs   (IF_ID_UsesRs),
        .IF_ID_UsesRt   (IF_ID_UsesRt),
        .IF_ID_MemWrite (IF_ID_MemWrite),
        .IF_ID_Halt     (IF_ID_Halt),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_Rd       (ID_EX_Rd),
        .branch_taken   (branch_taken),
        .dmem_busy      (dmem_busy),
        .PC_write       (PC_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_write   (EX_MEM_write),
        .MEM_WB_write   (MEM_WB_write),
        .halted         (halted),
        .mem_timeout    (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_write}
    localparam logic [5:0] O_RUN   = 6'b110011;
    localparam logic [5:0] O_STALL = 6'b000111;
    localparam logic [5:0] O_BR    = 6'b111011;
    localparam logic [5:0] O_HALT  = 6'b011011;
    localparam logic [5:0] O_DRAIN = 6'b000111;
    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_RST   = 6'b001100;

    typedef struct {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic       mw;
        logic       halt;
        logic       mr;
        logic [3:0] rd;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t       vt[11];
    logic [5:0] sb_q[$];
    int         n_chk;
    int         n_err;

    function automatic vec_t mk(
        input logic [3:0] rs, input logic [3:0] rt,
        input logic urs, input logic urt, input logic mw,
        input logic halt, input logic mr, input logic [3:0] rd,
        input logic br, input logic [5:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mw = mw;
        v.halt = halt; v.mr = mr; v.rd = rd; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        IF_ID_Rs       = v.rs;
        IF_ID_Rt       = v.rt;
        IF_ID_UsesRs   = v.urs;
        IF_ID_UsesRt   = v.urt;
        IF_ID_MemWrite = v.mw;
        IF_ID_Halt     = v.halt;
        ID_EX_MemRead  = v.mr;
        ID_EX_Rd       = v.rd;
        branch_taken   = v.br;
    endtask

    task automatic idle();
        set_in(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,
                  1'b0, O_RUN));
        dmem_busy = 1'b0;
    endtask

    // One cycle: queue expectation, compare mid-cycle, advance past edge.
    task automatic cyc(input string nm, input logic [5:0] exp);
        logic [5:0] e;
        sb_q.push_back(exp);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb_q.pop_front();
            chk(nm, {10'd0, PC_write, IF_ID_write, IF_ID_flush,
                     ID_EX_flush, EX_MEM_write, MEM_WB_write},
                {10'd0, e});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        idle();
        rst_n = 1'b0;
        cyc(nm, O_RST);
        rst_n = 1'b1;
        chk({nm, "_halted"}, {15'd0, halted}, 16'd0);
        chk({nm, "_tmo"}, {15'd0, mem_timeout}, 16'd0);
    endtask

    task automatic lu_inputs();
        set_in(mk(4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3,
                  1'b0, O_STALL));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        do_reset("reset");

        vt[0]  = mk(4'd3, 4'd5, 1, 1, 0, 0, 1, 4'd3, 0, O_STALL);
        vt[1]  = mk(4'd3, 4'd5, 1, 1, 0, 0, 0, 4'd3, 0, O_RUN);
        vt[2]  = mk(4'd0, 4'd5, 1, 1, 0, 0, 1, 4'd0, 0, O_RUN);
        vt[3]  = mk(4'd2, 4'd3, 1, 1, 1, 0, 1, 4'd3, 0, O_RUN);
        vt[4]  = mk(4'd1, 4'd3, 1, 1, 0, 0, 1, 4'd3, 0, O_STALL);
        vt[5]  = mk(4'd3, 4'd6, 0, 1, 0, 0, 1, 4'd3, 0, O_RUN);
        vt[6]  = mk(4'd1, 4'd2, 1, 1, 0, 0, 0, 4'd0, 1, O_BR);
        vt[7]  = mk(4'd7, 4'd2, 1, 1, 0, 0, 1, 4'd7, 1, O_STALL);
        vt[8]  = mk(4'd4, 4'd6, 1, 1, 0, 0, 1, 4'd5, 1, O_BR);
        vt[9]  = mk(4'd3, 4'd3, 1, 1, 1, 0, 1, 4'd3, 0, O_STALL);
        vt[10] = mk(4'd9, 4'd1, 1, 0, 0, 1, 1, 4'd9, 0, O_STALL);

        for (int i = 0; i < 11; i++) begin
            set_in(vt[i]);
            cyc($sformatf("vec%0d", i), vt[i].exp);
        end

        // Stall then branch resolves with fresh operands next cycle.
        lu_inputs();
        branch_taken = 1'b1;
        cyc("lu_br_stall", O_STALL);
        ID_EX_MemRead = 1'b0;
        cyc("lu_br_flush", O_BR);

        // Plain drain: halted on 4th edge counting the HALT edge.
        idle();
        IF_ID_Halt = 1'b1;
        cyc("halt_run", O_HALT);
        lu_inputs();
        branch_taken = 1'b1;
        cyc("drain0", O_DRAIN);
        cyc("drain1", O_DRAIN);
        chk("drain1_halted", {15'd0, halted}, 16'd0);
        cyc("drain2", O_DRAIN);
        chk("drain_done", {15'd0, halted}, 16'd1);
        cyc("halted_out", O_NONE);
        chk("halted_sticky", {15'd0, halted}, 16'd1);

        // Reset mid-drain returns to RUN.
        do_reset("rst2");
        IF_ID_Halt = 1'b1;
        cyc("halt_b", O_HALT);
        idle();
        cyc("drain_b0", O_DRAIN);
        do_reset("rst_mid");
        cyc("run_after_rst", O_RUN);

        // Drain with two freeze cycles in the middle.
        IF_ID_Halt = 1'b1;
        cyc("halt_c", O_HALT);
        idle();
        cyc("drain_c0", O_DRAIN);
        dmem_busy = 1'b1;
        cyc("freeze_c0", O_NONE);
        cyc("freeze_c1", O_NONE);
        dmem_busy = 1'b0;
        cyc("drain_c1", O_DRAIN);
        chk("frz_drain_halted", {15'd0, halted}, 16'd0);
        cyc("drain_c2", O_DRAIN);
        chk("frz_drain_done", {15'd0, halted}, 16'd1);

        // busy_cnt clears when dmem_busy drops.
        do_reset("rst3");
        dmem_busy = 1'b1;
        for (int i = 0; i < 10; i++) cyc("busy_a", O_NONE);
        dmem_busy = 1'b0;
        cyc("busy_gap", O_RUN);
        dmem_busy = 1'b1;
        for (int i = 0; i < 10; i++) cyc("busy_b", O_NONE);
        dmem_busy = 1'b0;
        chk("no_timeout", {15'd0, mem_timeout}, 16'd0);
        cyc("run_after_busy", O_RUN);

        // 16 consecutive busy cycles trip the timeout.
        dmem_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15)
                chk("tmo_at_15", {15'd0, mem_timeout}, 16'd0);
            cyc("tmo_freeze", O_NONE);
        end
        chk("tmo_set", {15'd0, mem_timeout}, 16'd1);
        dmem_busy = 1'b0;
        branch_taken = 1'b1;
        cyc("tmo_halted", O_NONE);
        chk("tmo_sticky", {15'd0, mem_timeout}, 16'd1);
        do_reset("rst4");
        cyc("run_after_tmo", O_RUN);

`ifdef HAZARD_PERF_CNT_EN
        do_reset("rst_perf");
        lu_inputs();
        cyc("perf_lu0", O_STALL);
        cyc("perf_lu1", O_STALL);
        idle();
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc("perf_frz", O_NONE);
        dmem_busy = 1'b0;
        branch_taken = 1'b1;
        cyc("perf_br", O_BR);
        idle();
        chk("stall_cnt", stall_cnt, 16'd5);
        chk("flush_cnt", flush_cnt, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
